// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the multi-channel UART configuration register file.
// Contents:
//   - Register address map constants.
//   - Reset defaults.
//   - The packed per-channel configuration record.
//   - The encoding of the access FSM states.
package uart_cfg_pkg;

    localparam logic [3:0] ADDR_RST_DEF = 4'h0;
    localparam logic [3:0] ADDR_PARITY  = 4'h1;
    localparam logic [3:0] ADDR_PTYPE   = 4'h2;
    localparam logic [3:0] ADDR_STOP    = 4'h3;
    localparam logic [3:0] ADDR_FLEN    = 4'h4;
    localparam logic [3:0] ADDR_STATUS  = 4'h5;

    localparam logic       DEF_PARITY = 1'b1;
    localparam logic       DEF_PTYPE  = 1'b0;
    localparam logic       DEF_STOP   = 1'b0;
    localparam logic [3:0] DEF_FLEN   = 4'd8;

    typedef struct packed {
        logic       parity;
        logic       parity_type;
        logic       stop_bits;
        logic [3:0] frame_length;
    } ch_cfg_t;

    localparam ch_cfg_t CFG_DEFAULT = '{
        parity:       DEF_PARITY,
        parity_type:  DEF_PTYPE,
        stop_bits:    DEF_STOP,
        frame_length: DEF_FLEN
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } acc_state_t;

endpackage

// File: rtl/uart_cfg_channel.sv
// One channel's configuration storage.
// The channel keeps two copies of its configuration:
//   - shadow: the copy that accesses write into.
//   - active: the copy that drives the UART.
// It also keeps a pending flag. While the flag is set and the channel is not
// busy, shadow is copied to active, and cfg_update_o pulses the following cycle.
// Ports:
//   clk_16bd, rst    clock and synchronous active-high reset
//   wr_en_i          load wr_cfg_i into shadow and mark pending
//   wr_cfg_i         full new shadow value (prepared by the top level)
//   busy_i           frame in progress; holds off commit
//   shadow_o         current shadow copy
//   active_o         current live configuration
//   pending_o        shadow not yet committed
//   cfg_update_o     one-cycle pulse after a commit
module uart_cfg_channel
    import uart_cfg_pkg::*;
(
    input  logic    clk_16bd,
    input  logic    rst,
    input  logic    wr_en_i,
    input  ch_cfg_t wr_cfg_i,
    input  logic    busy_i,
    output ch_cfg_t shadow_o,
    output ch_cfg_t active_o,
    output logic    pending_o,
    output logic    cfg_update_o
);

    ch_cfg_t shadow_q, shadow_d;
    ch_cfg_t active_q, active_d;
    logic    pending_q, pending_d;
    logic    update_q;
    logic    commit;

    // Commit uses the shadow as it stood before any write in the same cycle.
    // A same-cycle write keeps pending set, so the newer value commits later.
    always_comb begin
        commit    = pending_q & ~busy_i;
        active_d  = commit  ? shadow_q : active_q;
        shadow_d  = wr_en_i ? wr_cfg_i : shadow_q;
        pending_d = wr_en_i | (pending_q & ~commit);
    end

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            shadow_q  <= CFG_DEFAULT;
            active_q  <= CFG_DEFAULT;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            update_q  <= commit;
        end
    end

    assign shadow_o     = shadow_q;
    assign active_o     = active_q;
    assign pending_o    = pending_q;
    assign cfg_update_o = update_q;

endmodule

// File: rtl/uart_cfg_regfile.sv
// Multi-channel UART configuration register file on the clk_16bd domain.
// A single valid/ack access port reads and writes the shadow configuration of
// the channel selected by ch_sel. Each channel commits its shadow to its live
// outputs only while its busy bit is low.
// Ports:
//   clk_16bd, rst          clock and synchronous active-high reset
//   valid, rw              access request; rw=1 read, rw=0 write
//   ch_sel, address, data  target channel, register address, write data
//   busy                   per-channel frame in progress
//   ack, err               one-cycle acknowledge and error flag
//   data_out_valid         read data qualifier
//   data_out               read data (zero unless data_out_valid)
//   cfg_update             per-channel commit pulse
//   parity, parity_type    live configuration, one bit per channel
//   stop_bits              live configuration, one bit per channel
//   frame_length           live configuration, channel i at [4i+3:4i]
module uart_cfg_regfile
    import uart_cfg_pkg::*;
#(
    parameter int CH_W   = 1,
    parameter int DATA_W = 4,
    parameter int FL_MIN = 5,
    parameter int FL_MAX = 9
) (
    input  logic                  clk_16bd,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  rw,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [3:0]            address,
    input  logic [DATA_W-1:0]     data,
    input  logic [(2**CH_W)-1:0]  busy,
    output logic                  ack,
    output logic                  err,
    output logic                  data_out_valid,
    output logic [DATA_W-1:0]     data_out,
    output logic [(2**CH_W)-1:0]  cfg_update,
    output logic [(2**CH_W)-1:0]  parity,
    output logic [(2**CH_W)-1:0]  parity_type,
    output logic [(2**CH_W)-1:0]  stop_bits,
    output logic [4*(2**CH_W)-1:0] frame_length
);

    localparam int CH = 2**CH_W;

    acc_state_t        state_q;
    logic              ack_q, err_q, dov_q;
    logic [DATA_W-1:0] dout_q;

    ch_cfg_t           shadow [CH];
    ch_cfg_t           active [CH];
    logic [CH-1:0]     pending;
    logic [CH-1:0]     ch_wr_en;

    ch_cfg_t           sel_shadow;
    ch_cfg_t           wr_cfg;
    logic              wr_ok, rd_ok, accept;
    logic [DATA_W-1:0] rd_val;

    // Address decode. Writes are prepared as a complete new shadow record,
    // so each channel only has to load it.
    always_comb begin
        sel_shadow = shadow[ch_sel];
        wr_cfg     = sel_shadow;
        wr_ok      = 1'b0;
        rd_ok      = 1'b0;
        rd_val     = '0;
        unique case (address)
            ADDR_RST_DEF: begin
                if (!rw) begin
                    wr_ok  = 1'b1;
                    wr_cfg = CFG_DEFAULT;
                end
            end
            ADDR_PARITY: begin
                if (rw) begin
                    rd_ok     = 1'b1;
                    rd_val[0] = sel_shadow.parity;
                end else begin
                    wr_ok         = 1'b1;
                    wr_cfg.parity = data[0];
                end
            end
            ADDR_PTYPE: begin
                if (rw) begin
                    rd_ok     = 1'b1;
                    rd_val[0] = sel_shadow.parity_type;
                end else begin
                    wr_ok              = 1'b1;
                    wr_cfg.parity_type = data[0];
                end
            end
            ADDR_STOP: begin
                if (rw) begin
                    rd_ok     = 1'b1;
                    rd_val[0] = sel_shadow.stop_bits;
                end else begin
                    wr_ok            = 1'b1;
                    wr_cfg.stop_bits = data[0];
                end
            end
            ADDR_FLEN: begin
                if (rw) begin
                    rd_ok       = 1'b1;
                    rd_val[3:0] = sel_shadow.frame_length;
                end else if ((int'(data[3:0]) >= FL_MIN) && (int'(data[3:0]) <= FL_MAX)) begin
                    wr_ok               = 1'b1;
                    wr_cfg.frame_length = data[3:0];
                end
            end
            ADDR_STATUS: begin
                if (rw) begin
                    rd_ok     = 1'b1;
                    rd_val[0] = pending[ch_sel];
                    rd_val[1] = busy[ch_sel];
                end
            end
            default: ;
        endcase
    end

    assign accept = (state_q == ST_IDLE) && valid;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            ch_wr_en[i] = accept && !rw && wr_ok && (ch_sel == CH_W'(i));
        end
    end

    // Access FSM with registered response. The response is decided in the
    // request cycle and presented for the one RESP cycle.
    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dov_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (valid) begin
                        state_q <= ST_RESP;
                        ack_q   <= 1'b1;
                        err_q   <= !(rd_ok || wr_ok);
                        dov_q   <= rd_ok;
                        dout_q  <= rd_ok ? rd_val : '0;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    dov_q   <= 1'b0;
                    dout_q  <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        uart_cfg_channel u_ch (
            .clk_16bd     (clk_16bd),
            .rst          (rst),
            .wr_en_i      (ch_wr_en[g]),
            .wr_cfg_i     (wr_cfg),
            .busy_i       (busy[g]),
            .shadow_o     (shadow[g]),
            .active_o     (active[g]),
            .pending_o    (pending[g]),
            .cfg_update_o (cfg_update[g])
        );

        assign parity[g]               = active[g].parity;
        assign parity_type[g]          = active[g].parity_type;
        assign stop_bits[g]            = active[g].stop_bits;
        assign frame_length[4*g +: 4]  = active[g].frame_length;
    end

    assign ack            = ack_q;
    assign err            = err_q;
    assign data_out_valid = dov_q;
    assign data_out       = dout_q;

endmodule

// File: tb/tb_uart_cfg_regfile.sv
module tb_uart_cfg_regfile;

    localparam int CH = 2;

    logic       clk_16bd = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       rw = 1'b0;
    logic [0:0] ch_sel = '0;
    logic [3:0] address = '0;
    logic [3:0] data = '0;
    logic [1:0] busy = '0;
    logic       ack, err, data_out_valid;
    logic [3:0] data_out;
    logic [1:0] cfg_update, parity, parity_type, stop_bits;
    logic [7:0] frame_length;

    uart_cfg_regfile #(.CH_W(1), .DATA_W(4), .FL_MIN(5), .FL_MAX(9)) dut (
        .clk_16bd       (clk_16bd),
        .rst            (rst),
        .valid          (valid),
        .rw             (rw),
        .ch_sel         (ch_sel),
        .address        (address),
        .data           (data),
        .busy           (busy),
        .ack            (ack),
        .err            (err),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .cfg_update     (cfg_update),
        .parity         (parity),
        .parity_type    (parity_type),
        .stop_bits      (stop_bits),
        .frame_length   (frame_length)
    );

    always #5 clk_16bd = ~clk_16bd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: configuration held as a table indexed by register
    // address (1..4), one shadow and one live table per channel.
    int  def_cfg [5] = '{0, 1, 0, 0, 8};
    int  sh  [CH][5];
    int  act [CH][5];
    bit  pend [CH];
    bit  in_resp;
    bit  e_ack, e_err, e_dov;
    int  e_dout;
    bit [1:0] e_upd;

    function automatic void model_cycle();
        bit do_wr;
        int wc;
        int nv [5];
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                sh[c] = def_cfg; act[c] = def_cfg; pend[c] = 0;
            end
            in_resp = 0; e_ack = 0; e_err = 0; e_dov = 0; e_dout = 0; e_upd = '0;
            return;
        end
        do_wr = 0; wc = int'(ch_sel); nv = sh[wc];
        e_ack = 0; e_err = 0; e_dov = 0; e_dout = 0;
        if (!in_resp && valid) begin
            e_ack = 1;
            in_resp = 1;
            if (rw) begin
                if (address >= 1 && address <= 4) begin
                    e_dov = 1; e_dout = sh[wc][address];
                end else if (address == 5) begin
                    e_dov = 1; e_dout = 2 * int'(busy[wc]) + int'(pend[wc]);
                end else e_err = 1;
            end else begin
                if (address == 0) begin
                    do_wr = 1; nv = def_cfg;
                end else if (address >= 1 && address <= 3) begin
                    do_wr = 1; nv[address] = int'(data) % 2;
                end else if (address == 4 && data >= 5 && data <= 9) begin
                    do_wr = 1; nv[4] = int'(data);
                end else e_err = 1;
            end
        end else begin
            in_resp = 0;
        end
        for (int c = 0; c < CH; c++) begin
            e_upd[c] = pend[c] && !busy[c];
            if (e_upd[c]) begin
                act[c] = sh[c]; pend[c] = 0;
            end
        end
        if (do_wr) begin
            sh[wc] = nv; pend[wc] = 1;
        end
    endfunction

    task automatic compare_all();
        logic [1:0] xp, xt, xs;
        logic [7:0] xf;
        for (int c = 0; c < CH; c++) begin
            xp[c] = act[c][1][0];
            xt[c] = act[c][2][0];
            xs[c] = act[c][3][0];
            xf[4*c +: 4] = 4'(act[c][4]);
        end
        check("ack", 32'(ack), 32'(e_ack));
        check("err", 32'(err), 32'(e_err));
        check("dov", 32'(data_out_valid), 32'(e_dov));
        check("dout", 32'(data_out), 32'(e_dout));
        check("cfg_update", 32'(cfg_update), 32'(e_upd));
        check("parity", 32'(parity), 32'(xp));
        check("ptype", 32'(parity_type), 32'(xt));
        check("stop", 32'(stop_bits), 32'(xs));
        check("flen", 32'(frame_length), 32'(xf));
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk_16bd);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit r, input bit v, input bit w_rw, input int c,
                         input int a, input int d, input bit [1:0] b);
        rst = r; valid = v; rw = w_rw; ch_sel = 1'(c);
        address = 4'(a); data = 4'(d); busy = b;
        step();
    endtask

    initial begin
        int n_ack;
        // reset, then read ch0 frame_length
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        drive(0, 1, 1, 0, 4, 0, 2'b00);
        check("tp_rd_flen_dout", 32'(data_out), 32'd8);
        check("tp_rd_flen_dov", 32'(data_out_valid), 32'd1);
        check("tp_rst_flen", 32'(frame_length), 32'h88);
        check("tp_rst_parity", 32'(parity), 32'h3);
        drive(0, 0, 0, 0, 0, 0, 2'b00);

        // busy[1] blocks commit of a parity write
        drive(0, 1, 0, 1, 1, 0, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 2'b10);
        check("tp_busy_hold_parity", 32'(parity[1]), 32'd1);
        drive(0, 1, 1, 1, 5, 0, 2'b10);
        check("tp_status", 32'(data_out), 32'h3);
        drive(0, 0, 0, 0, 0, 0, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        check("tp_commit_parity", 32'(parity[1]), 32'd0);
        check("tp_commit_pulse", 32'(cfg_update), 32'h2);
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        check("tp_pulse_end", 32'(cfg_update), 32'h0);

        // illegal frame length, invalid read, write to status
        drive(0, 1, 0, 0, 4, 10, 2'b00);
        check("tp_flen_err", 32'(err), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        check("tp_flen_kept", 32'(frame_length[3:0]), 32'd8);
        drive(0, 1, 1, 0, 7, 0, 2'b00);
        check("tp_bad_addr_err", 32'(err), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        drive(0, 1, 0, 1, 5, 3, 2'b00);
        check("tp_wr_status_err", 32'(err), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 2'b00);

        // valid held high for six cycles
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 0, 2, 0, 2'b00);
            if (ack) n_ack++;
        end
        check("tp_held_valid_acks", 32'(n_ack), 32'd3);
        // write lands, then reset during RESP
        drive(0, 1, 0, 0, 3, 1, 2'b01);
        drive(1, 0, 0, 0, 0, 0, 2'b01);
        check("tp_rst_in_resp_ack", 32'(ack), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        check("tp_rst_no_commit", 32'(stop_bits), 32'd0);

        // write coinciding with commit of an older pending value
        drive(0, 1, 0, 0, 2, 1, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 2'b01);
        drive(0, 1, 0, 0, 2, 0, 2'b00);
        check("tp_same_old_commit", 32'(parity_type[0]), 32'd1);
        check("tp_same_pulse1", 32'(cfg_update[0]), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        check("tp_same_new_commit", 32'(parity_type[0]), 32'd0);
        check("tp_same_pulse2", 32'(cfg_update[0]), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit [1:0] b;
            int a;
            b = busy;
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 3) == 0) b[c] = ~b[c];
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(0, 5));
            drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  int'($urandom_range(0, 1)), a, int'($urandom_range(0, 15)), b);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cfg_regfile.md
Name: uart_cfg_regfile

Overview:
- Multi-channel successor to the single-channel UART configuration register file, on the clk_16bd domain.
- Holds parity, parity type, stop bits and frame length for CH independent UART channels behind one valid/ack access port.
- Adds explicit read/write, error response and shadow/active double-buffering.
- Writes land in a shadow copy. Shadow is committed to the live outputs only when that channel's transmitter/receiver reports idle, so a frame in flight never changes configuration.

Parameters:
- CH_W, 1, channel-select width; CH = 2**CH_W channels
- DATA_W, 4, access data width (must be >= 4)
- FL_MIN, 5, smallest legal frame_length
- FL_MAX, 9, largest legal frame_length

Ports:
- clk_16bd  in  1  16x-baud clock; only clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  access request
- rw  in  1  1 = read, 0 = write
- ch_sel  in  CH_W  target channel
- address  in  4  register address
- data  in  DATA_W  write data
- busy  in  CH  per-channel "frame in progress"; blocks commit
- ack  out  1  one-cycle access acknowledge
- err  out  1  one-cycle error flag, coincident with ack
- data_out_valid  out  1  read data valid, coincident with ack
- data_out  out  DATA_W  read data; zero when data_out_valid=0
- cfg_update  out  CH  one-cycle pulse when a channel's active config changes by commit
- parity  out  CH  active parity enable per channel
- parity_type  out  CH  active parity type per channel
- stop_bits  out  CH  active stop-bit select per channel
- frame_length  out  4*CH  active frame length; channel i at bits [4i+3:4i]

Behaviour:
- Reset (sync, rst=1 at clock edge), all channels, shadow and active: parity=1, parity_type=0, stop_bits=0, frame_length=8, pending=0. Outputs: ack=0, err=0, data_out_valid=0, data_out=0, cfg_update=0. Reset overrides any access or commit in the same cycle.
- Access FSM, states IDLE and RESP:
  - IDLE: valid=1 accepts the request, goes to RESP.
  - RESP: outputs registered response for exactly one cycle, returns to IDLE. valid is ignored in RESP.
  - valid held high re-issues the same access every 2 cycles.
  - Latency: request cycle N gives ack=1 in cycle N+1.
- Address map (per ch_sel):
  - 0x0 write: load defaults into shadow, set pending. Read: err.
  - 0x1 parity, shadow bit 0.
  - 0x2 parity_type, shadow bit 0.
  - 0x3 stop_bits, shadow bit 0.
  - 0x4 frame_length, shadow [3:0].
  - 0x5 read-only status: data_out[0]=pending[ch], data_out[1]=busy[ch]. Write: err.
  - Any other address: err.
- Writes (0x1-0x4) update shadow and set pending[ch]. Only data bit 0 (or [3:0] for 0x4) is used; the rest is ignored.
- frame_length write outside FL_MIN..FL_MAX: err=1, shadow unchanged, pending unchanged.
- Reads return the shadow value zero-extended to DATA_W, with data_out_valid=1, err=0.
- On err: ack=1, data_out_valid=0, data_out=0.
- Commit, every cycle, per channel, independent of the FSM: if pending[i]=1 and busy[i]=0, then active<=shadow, pending[i]<=0, and cfg_update[i]=1 the next cycle.
- Write and commit in the same cycle on the same channel: commit copies the pre-write shadow, pending stays 1 (write wins), and the new value commits at the next idle cycle.
- busy held high indefinitely: pending stays 1 and active is unchanged. Multiple writes coalesce; only the latest shadow commits.
- cfg_update fires even if shadow equals active (commit occurred).

Decomposition:
- Package uart_cfg_pkg:
  - address constants (ADDR_RST_DEF, ADDR_PARITY, ADDR_PTYPE, ADDR_STOP, ADDR_FLEN, ADDR_STATUS)
  - reset defaults (DEF_PARITY=1, DEF_PTYPE=0, DEF_STOP=0, DEF_FLEN=8)
  - a packed struct for one channel's config (parity, parity_type, stop_bits, frame_length[3:0])
- Sub-module uart_cfg_channel: one channel's shadow/active/pending registers, commit logic, cfg_update pulse. Instantiated CH times via generate.
- Top level: access FSM, decode, response mux.

Test Plan:
- Reset then read ch0 addr 0x4 -> ack=1, data_out=8, data_out_valid=1, err=0 one cycle after valid. Outputs: parity=all 1, frame_length=0x88.
- busy[1]=1; write ch1 0x1 data=0 -> ack, parity[1] stays 1, status read gives data_out=0b11. Drop busy[1] -> next cycle parity[1]=0, cfg_update[1] one-cycle pulse, pending cleared.
- Write ch0 0x4 data=10 -> ack=1, err=1, frame_length ch0 stays 8, no cfg_update.
- Read invalid addr 0x7 and write addr 0x5 -> each ack=1, err=1, data_out=0.
- valid held high 6 cycles -> exactly 3 ack pulses, alternating cycles. rst asserted during RESP -> next cycle ack=0 and all defaults restored.
- busy[0]=0 with a write to ch0 0x2 in the same cycle a prior pending commits -> old value committed with cfg_update, pending remains 1, new value commits next cycle with a second cfg_update pulse.
